// File: rtl/error_injector.sv
// Single-stage fault injector: flips at most one bit per word (PASS/RANDOM/BURST/WALK), 1-cycle latency.
// Stalls when the output register is full and out_ready is low; the LFSR advances only on accepted words.
module error_injector #(
  parameter int          N    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic [7:0]   rate,
  input  logic [3:0]   burst_len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_flip_mask,
  output logic [15:0]  err_count
);

  localparam int          PW       = $clog2(N);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [PW-1:0] LAST   = PW'(N - 1);
  localparam logic [7:0]  N8       = 8'(N);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_RANDOM = 2'b01;
  localparam logic [1:0] MODE_BURST  = 2'b10;
  localparam logic [1:0] MODE_WALK   = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state_q, state_d;
  logic [3:0]    rem_q, rem_d;
  logic [PW-1:0] bpos_q, bpos_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [15:0]   lfsr_q, lfsr_nxt;
  logic [N-1:0]  mask;
  logic [PW-1:0] pos_rand;
  logic          trigger;
  logic          accept;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign trigger  = (rate == 8'hFF) || (lfsr_q[7:0] < rate);
  assign pos_rand = PW'(lfsr_q[15:8] % N8);
  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    mask    = '0;
    state_d = state_q;
    rem_d   = rem_q;
    bpos_d  = bpos_q;
    wptr_d  = wptr_q;
    if (accept) begin
      // Any non-BURST word aborts a burst in progress.
      state_d = IDLE;
      rem_d   = '0;
      case (mode)
        MODE_RANDOM: begin
          if (trigger) mask = ONE << pos_rand;
        end
        MODE_BURST: begin
          if (state_q == BURST) begin
            mask    = ONE << bpos_q;
            bpos_d  = inc_mod(bpos_q);
            rem_d   = rem_q - 4'd1;
            state_d = (rem_q == 4'd1) ? IDLE : BURST;
          end else begin
            if (trigger) mask = ONE << pos_rand;
            if (trigger && burst_len != 4'd0) begin
              state_d = BURST;
              rem_d   = burst_len;
              bpos_d  = inc_mod(pos_rand);
            end
          end
        end
        MODE_WALK: begin
          mask   = ONE << wptr_q;
          wptr_d = inc_mod(wptr_q);
        end
        default: mask = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      bpos_q        <= '0;
      wptr_q        <= '0;
      lfsr_q        <= SEED_EFF;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_flip_mask <= '0;
      err_count     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bpos_q  <= bpos_d;
      wptr_q  <= wptr_d;
      if (accept) begin
        lfsr_q        <= lfsr_nxt;
        out_valid     <= 1'b1;
        out_data      <= in_data ^ mask;
        out_flip_mask <= mask;
        if ((|mask) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/error_injector.md
ERROR_INJECTOR -- requirements
Module: error_injector

Interface
REQ-001 Parameter N, default 8, data word width in bits; legal range 2..64.
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; a SEED of 0 SHALL be replaced internally by 16'h0001.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  2  injection mode: 00 PASS, 01 RANDOM, 10 BURST, 11 WALK.
REQ-006 rate  input  8  error probability threshold; 8'hFF means always inject.
REQ-007 burst_len  input  4  extra corrupted words following a BURST trigger.
REQ-008 in_valid / in_ready  input / output  1 / 1  upstream handshake.
REQ-009 in_data  input  N  clean data word.
REQ-010 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-011 out_data  output  N  possibly corrupted word.
REQ-012 out_flip_mask  output  N  bits flipped in out_data (1 = flipped).
REQ-013 err_count  output  16  number of corrupted words emitted, saturating.

Function
REQ-014 Single registered stage; in_ready SHALL equal (!out_valid || out_ready); a word is accepted when in_valid && in_ready.
REQ-015 On accept: out_data <= in_data ^ mask, out_flip_mask <= mask, out_valid <= 1; latency is exactly 1 cycle.
REQ-016 Without accept, if out_ready is 1 then out_valid <= 0; otherwise out_valid, out_data and out_flip_mask SHALL hold stable.
REQ-017 LFSR: 16-bit Galois, taps 16'hB400, shift right; it advances once per accepted word only and never reaches 0.
REQ-018 Trigger = (rate == 8'hFF) || (lfsr[7:0] < rate), evaluated on the current (pre-advance) LFSR value.
REQ-019 pos_rand = lfsr[15:8] mod N.
REQ-020 Every mask has at most one bit set.
REQ-021 PASS: mask = 0; no other state changes except the LFSR advance.
REQ-022 RANDOM: mask = trigger ? one-hot(pos_rand) : 0.
REQ-023 BURST uses FSM states IDLE and BURST, with a 4-bit remaining counter and a position register bpos.
REQ-024 BURST, in IDLE: mask = trigger ? one-hot(pos_rand) : 0; on trigger with burst_len != 0, go to BURST with remaining = burst_len and bpos = (pos_rand + 1) mod N.
REQ-025 BURST, in BURST: mask = one-hot(bpos); bpos <= (bpos + 1) mod N and remaining decrements; return to IDLE when remaining reaches 0 (decrement from 1); no trigger evaluation occurs while in BURST.
REQ-026 WALK: mask = one-hot(wptr); wptr <= (wptr + 1) mod N; wptr wraps from N-1 to 0 and holds its value when mode != WALK.
REQ-027 mode and burst_len SHALL be sampled only on accept; an accepted word with mode != BURST forces the FSM to IDLE, aborting any burst.
REQ-028 err_count increments by 1 per accepted word with a nonzero mask and saturates at 16'hFFFF.
REQ-029 in_data SHALL never be modified beyond the bits set in the mask.

Reset
REQ-030 On reset: out_valid = 0, out_data = 0, out_flip_mask = 0, err_count = 0, lfsr = SEED, FSM = IDLE, remaining = 0, bpos = 0, wptr = 0.
REQ-031 Reset SHALL override any simultaneous accept; a burst in progress is discarded, and in_ready reads 1 in the first cycle after reset.

Verification
REQ-032 PASS, N=8: in_data 8'hA5 with out_ready=1 -> out_data 8'hA5 and mask 0 one cycle later; err_count stays 0.
REQ-033 WALK, N=8: ten words of 8'h00 -> masks 01,02,04,08,10,20,40,80,01,02; err_count = 10.
REQ-034 RANDOM, rate=0: 1000 words -> all masks 0. RANDOM, rate=FF: every mask one-hot and err_count = words accepted.
REQ-035 BURST, rate=FF, burst_len=3: trigger word at position p, then positions p+1, p+2, p+3 mod N, then a new trigger; a mode change to PASS mid-burst gives mask 0 immediately.
REQ-036 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0 and outputs stable; the LFSR does not advance (the same mask sequence as the no-stall run).
REQ-037 Saturation: force 65540 corrupted words -> err_count = FFFF. Assert reset mid-burst -> all REQ-030 values on the next cycle.
